// File: rtl/sram_pkg.sv
// Shared types and default sizing for the N-read/1-write synchronous SRAM.
// Parity support in the users of this package is enabled by defining SRAM_PARITY_EN.
package sram_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_DEPTH  = 8192;
  localparam int DEF_NRD    = 2;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sramState_e;

  // Address width for a given depth; a single-word array still needs one address bit
  function automatic int addrWidth(input int depth);
    int aw;
    if (depth > 1) begin
      aw = $clog2(depth);
    end else begin
      aw = 1;
    end
    return aw;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-delivery shift register for one read port; data only advances with valid so the
// last delivered word stays on the output. SRAM_PARITY_EN adds a parity-error lane.
module sram_rd_pipe #(
  parameter int WIDTH  = 128,
  parameter int STAGES = 1
) (
  input  logic             clock,
  input  logic             reset,
`ifdef SRAM_PARITY_EN
  input  logic             errIn,
  output logic             errOut,
`endif
  input  logic [WIDTH-1:0] dataIn,
  input  logic             validIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             validOut
);

  if (STAGES == 0) begin : gPass
    assign dataOut  = dataIn;
    assign validOut = validIn;
`ifdef SRAM_PARITY_EN
    assign errOut   = errIn;
`endif
  end else begin : gShift
    logic [WIDTH-1:0]  data_r [STAGES];
    logic [STAGES-1:0] valid_r;
`ifdef SRAM_PARITY_EN
    logic [STAGES-1:0] err_r;
`endif

    // Shift valid every cycle; capture data only when a word is moving into the stage
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) begin
          data_r[i] <= '0;
        end
        valid_r <= '0;
`ifdef SRAM_PARITY_EN
        err_r   <= '0;
`endif
      end else begin
        valid_r[0] <= validIn;
        if (validIn) begin
          data_r[0] <= dataIn;
        end
`ifdef SRAM_PARITY_EN
        err_r[0] <= errIn;
`endif
        for (int i = 1; i < STAGES; i++) begin
          valid_r[i] <= valid_r[i-1];
          if (valid_r[i-1]) begin
            data_r[i] <= data_r[i-1];
          end
`ifdef SRAM_PARITY_EN
          err_r[i] <= err_r[i-1];
`endif
        end
      end
    end

    assign dataOut  = data_r[STAGES-1];
    assign validOut = valid_r[STAGES-1];
`ifdef SRAM_PARITY_EN
    assign errOut   = err_r[STAGES-1];
`endif
  end

endmodule

// File: rtl/sram_nr1w_sync.sv
// Synchronous SRAM, one write port and NRD pipelined read ports, write-first bypass and a
// hardware clear engine. Define SRAM_PARITY_EN to store and check one parity bit per word.
module sram_nr1w_sync
  import sram_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = DEF_NRD,
  parameter int RD_LAT = DEF_RD_LAT,
  localparam int AW    = addrWidth(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NRD-1:0]       rd_req,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid,
`ifdef SRAM_PARITY_EN
  input  logic                 wr_par_flip,
  output logic [NRD-1:0]       parity_err,
`endif
  input  logic                 clr_start,
  output logic                 busy
);

`ifdef SRAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [MW-1:0] mem [DEPTH];

  sramState_e    state_r, nextState_s;
  logic [AW-1:0] clrCnt_r, nextClrCnt_s;
  logic          busy_r;
  logic          wrInRange_s, wrDo_s;
  logic          memWe_s;
  logic [AW-1:0] memWaddr_s;
  logic [MW-1:0] memWdata_s, wrWord_s;

`ifdef SRAM_PARITY_EN
  function automatic logic evenParity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  assign wrWord_s = {evenParity(wr_data) ^ wr_par_flip, wr_data};
`else
  assign wrWord_s = wr_data;
`endif

  if (DEPTH == (2 ** AW)) begin : gWrPow2
    assign wrInRange_s = 1'b1;
  end else begin : gWrNp2
    assign wrInRange_s = (wr_addr < AW'(DEPTH));
  end

  assign wrDo_s = wr_en && !busy_r && wrInRange_s;
  assign busy   = busy_r;

  // Clear engine: sweep every address once, then return to idle
  always_comb begin
    nextState_s  = state_r;
    nextClrCnt_s = clrCnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_start) begin
          nextState_s = ST_CLEAR;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clrCnt_r == AW'(DEPTH - 1)) begin
          nextState_s  = ST_IDLE;
          nextClrCnt_s = '0;
        end else begin
          nextClrCnt_s = clrCnt_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        nextState_s  = ST_IDLE;
        nextClrCnt_s = '0;
      end
    endcase
  end

  // FSM state, clear counter and busy flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      clrCnt_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= nextState_s;
      clrCnt_r <= nextClrCnt_s;
      busy_r   <= (nextState_s == ST_CLEAR);
    end
  end

  // Array write port shared between the clear engine and user writes
  always_comb begin
    memWe_s    = 1'b0;
    memWaddr_s = wr_addr;
    memWdata_s = wrWord_s;
    if (state_r == ST_CLEAR) begin
      memWe_s    = 1'b1;
      memWaddr_s = clrCnt_r;
      memWdata_s = '0;
    end else if (wrDo_s) begin
      memWe_s = 1'b1;
    end else begin
      memWe_s = 1'b0;
    end
  end

  // Array storage; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (memWe_s) begin
      mem[memWaddr_s] <= memWdata_s;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : gRd
    logic [AW-1:0]    addr_s;
    logic             inRange_s, accept_s;
    logic [MW-1:0]    word_s;
    logic [WIDTH-1:0] stData_r;
    logic             stValid_r;
`ifdef SRAM_PARITY_EN
    logic             stErr_r;
`endif

    assign addr_s   = rd_addr[p*AW +: AW];
    assign accept_s = rd_req[p] && !busy_r;

    if (DEPTH == (2 ** AW)) begin : gRdPow2
      assign inRange_s = 1'b1;
    end else begin : gRdNp2
      assign inRange_s = (addr_s < AW'(DEPTH));
    end

    // Read word selection with write-first bypass
    always_comb begin
      word_s = '0;
      if (!inRange_s) begin
        word_s = '0;
      end else if (wrDo_s && (wr_addr == addr_s)) begin
        word_s = wrWord_s;
      end else begin
        word_s = mem[addr_s];
      end
    end

    // First read stage: sample the array at the request edge
    always_ff @(posedge clock) begin
      if (reset) begin
        stData_r  <= '0;
        stValid_r <= 1'b0;
`ifdef SRAM_PARITY_EN
        stErr_r   <= 1'b0;
`endif
      end else begin
        stValid_r <= accept_s;
        if (accept_s) begin
          stData_r <= word_s[WIDTH-1:0];
        end
`ifdef SRAM_PARITY_EN
        stErr_r <= accept_s && (evenParity(word_s[WIDTH-1:0]) != word_s[WIDTH]);
`endif
      end
    end

    sram_rd_pipe #(
      .WIDTH (WIDTH),
      .STAGES(RD_LAT - 1)
    ) uPipe (
      .clock   (clock),
      .reset   (reset),
`ifdef SRAM_PARITY_EN
      .errIn   (stErr_r),
      .errOut  (parity_err[p]),
`endif
      .dataIn  (stData_r),
      .validIn (stValid_r),
      .dataOut (rd_data[p*WIDTH +: WIDTH]),
      .validOut(rd_valid[p])
    );
  end

endmodule
